// File: rtl/vsb_pkg.sv
// Shared definitions for the vector stream buffer: default sizes and a
// width helper used by every file of the block.
package vsb_pkg;

    localparam int NUM_DIMENSIONS_DEF = 32;
    localparam int DATA_WIDTH_DEF     = 32;
    localparam int NUM_VECTORS_DEF    = 4;

    // Pointer width for a range of n values; never narrower than one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vsb_mod_counter.sv
// Modulo-MAX counter with synchronous clear and an increment input.
// wrap_o flags the increment that returns the count to zero.
module vsb_mod_counter
    import vsb_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = safe_clog2(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q, count_d;

    assign count_o = count_q;
    assign wrap_o  = inc_i && (count_q == W'(MAX - 1));

    // Next count: clear wins over increment; increment wraps at MAX-1.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = wrap_o ? '0 : count_q + W'(1);
        end
    end

    // Count register.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vector_stream_buffer.sv
// Circular buffer of NUM_VECTORS feature vectors. Elements stream in one per
// cycle; a vector becomes readable only once complete. The reader streams the
// head vector with index/last and may replay it instead of consuming it.
// Build option: define VSB_MEM_CLEAR_EN to zero the storage on rst and flush.
module vector_stream_buffer
    import vsb_pkg::*;
#(
    parameter int  NUM_DIMENSIONS = NUM_DIMENSIONS_DEF,
    parameter int  DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int  NUM_VECTORS    = NUM_VECTORS_DEF,
    localparam int DIM_W          = safe_clog2(NUM_DIMENSIONS),
    localparam int PTR_W          = safe_clog2(NUM_VECTORS),
    localparam int CNT_W          = $clog2(NUM_VECTORS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DIM_W-1:0]      out_index,
    output logic                  out_last,
    input  logic                  replay,
    input  logic                  flush,
    output logic [CNT_W-1:0]      vec_count,
    output logic                  full,
    output logic                  empty
);

    logic [DIM_W-1:0] wr_dim, rd_dim;
    logic [PTR_W-1:0] wr_vec, rd_vec;
    logic             wr_fire, rd_fire;
    logic             commit, rd_dim_wrap, pop;
    logic             wr_vec_wrap, rd_vec_wrap;
    logic             unused_ok;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;

    logic [DATA_WIDTH-1:0] mem_q [NUM_VECTORS][NUM_DIMENSIONS];

    // Status decoded from the registered count only, so a freed slot shows
    // up as in_ready one cycle after the pop.
    assign full      = (vec_count_q == CNT_W'(NUM_VECTORS));
    assign empty     = (vec_count_q == '0);
    assign vec_count = vec_count_q;
    assign in_ready  = !full;
    assign out_valid = !empty;

    // A flush cycle swallows both handshakes.
    assign wr_fire = in_valid && in_ready && !flush;
    assign rd_fire = out_valid && out_ready && !flush;
    assign pop     = rd_dim_wrap && !replay;

    assign out_data  = mem_q[rd_vec][rd_dim];
    assign out_index = rd_dim;
    assign out_last  = (rd_dim == DIM_W'(NUM_DIMENSIONS - 1));

    // Slot pointers wrap naturally at NUM_VECTORS; their wraps carry no meaning.
    assign unused_ok = &{1'b0, wr_vec_wrap, rd_vec_wrap};

    vsb_mod_counter #(.MAX(NUM_DIMENSIONS), .W(DIM_W)) u_wr_dim (
        .clk(clk), .rst(rst), .clr_i(flush), .inc_i(wr_fire),
        .count_o(wr_dim), .wrap_o(commit)
    );

    vsb_mod_counter #(.MAX(NUM_VECTORS), .W(PTR_W)) u_wr_vec (
        .clk(clk), .rst(rst), .clr_i(flush), .inc_i(commit),
        .count_o(wr_vec), .wrap_o(wr_vec_wrap)
    );

    vsb_mod_counter #(.MAX(NUM_DIMENSIONS), .W(DIM_W)) u_rd_dim (
        .clk(clk), .rst(rst), .clr_i(flush), .inc_i(rd_fire),
        .count_o(rd_dim), .wrap_o(rd_dim_wrap)
    );

    vsb_mod_counter #(.MAX(NUM_VECTORS), .W(PTR_W)) u_rd_vec (
        .clk(clk), .rst(rst), .clr_i(flush), .inc_i(pop),
        .count_o(rd_vec), .wrap_o(rd_vec_wrap)
    );

    // Committed-vector count: +1 on commit, -1 on pop, cleared by flush.
    always_comb begin
        vec_count_d = vec_count_q;
        if (flush) begin
            vec_count_d = '0;
        end else begin
            vec_count_d = vec_count_q + CNT_W'(commit) - CNT_W'(pop);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count_q <= '0;
        end else begin
            vec_count_q <= vec_count_d;
        end
    end

`ifdef VSB_MEM_CLEAR_EN
    // Element storage, zeroed on reset and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VECTORS; v++) begin
                for (int d = 0; d < NUM_DIMENSIONS; d++) begin
                    mem_q[v][d] <= '0;
                end
            end
        end else if (flush) begin
            for (int v = 0; v < NUM_VECTORS; v++) begin
                for (int d = 0; d < NUM_DIMENSIONS; d++) begin
                    mem_q[v][d] <= '0;
                end
            end
        end else if (wr_fire) begin
            mem_q[wr_vec][wr_dim] <= in_data;
        end
    end
`else
    // Element storage written at the write pointer.
    // NOTE: the array is deliberately left without reset so it can map onto
    // RAM; contents are only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_vec][wr_dim] <= in_data;
        end
    end
`endif

endmodule

// File: tb/tb_vector_stream_buffer.sv
// Self-checking bench for vector_stream_buffer: directed scenarios followed by
// random traffic, checked by a queue-based reference model at each negedge.
module tb_vector_stream_buffer;

    localparam int ND    = 32;
    localparam int DW    = 32;
    localparam int NV    = 4;
    localparam int DIM_W = 5;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid, out_ready;
    logic [DW-1:0]    out_data;
    logic [DIM_W-1:0] out_index;
    logic             out_last;
    logic             replay, flush;
    logic [CNT_W-1:0] vec_count;
    logic             full, empty;

    int n_checks = 0;
    int n_pass   = 0;

    vector_stream_buffer #(.NUM_DIMENSIONS(ND), .DATA_WIDTH(DW), .NUM_VECTORS(NV)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last),
        .replay(replay), .flush(flush),
        .vec_count(vec_count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: committed elements in arrival order (head vector is
    // the first ND entries), the vector under construction, and the read
    // position inside the head vector.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_elems[$];
    logic [DW-1:0] m_part[$];
    int            m_rd_idx = 0;

    always @(negedge clk) begin
        int cnt;
        cnt = m_elems.size() / ND;
        if (rst) begin
            check("rst_in_ready",  64'(in_ready),  64'(1));
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_out_index", 64'(out_index), 64'(0));
            check("rst_out_last",  64'(out_last),  64'(0));
            check("rst_vec_count", 64'(vec_count), 64'(0));
            check("rst_full",      64'(full),      64'(0));
            check("rst_empty",     64'(empty),     64'(1));
            m_elems.delete();
            m_part.delete();
            m_rd_idx = 0;
        end else begin
            check("vec_count", 64'(vec_count), 64'(cnt));
            check("full",      64'(full),      64'(cnt == NV));
            check("empty",     64'(empty),     64'(cnt == 0));
            check("in_ready",  64'(in_ready),  64'(cnt < NV));
            check("out_valid", 64'(out_valid), 64'(cnt > 0));
            if (cnt > 0) begin
                check("out_data",  64'(out_data),  64'(m_elems[m_rd_idx]));
                check("out_index", 64'(out_index), 64'(m_rd_idx));
                check("out_last",  64'(out_last),  64'(m_rd_idx == ND - 1));
            end
            if (flush) begin
                m_elems.delete();
                m_part.delete();
                m_rd_idx = 0;
            end else begin
                if (cnt > 0 && out_ready) begin
                    if (m_rd_idx == ND - 1) begin
                        m_rd_idx = 0;
                        if (!replay) for (int i = 0; i < ND; i++) void'(m_elems.pop_front());
                    end else begin
                        m_rd_idx++;
                    end
                end
                if (in_valid && cnt < NV) begin
                    m_part.push_back(in_data);
                    if (m_part.size() == ND) begin
                        foreach (m_part[i]) m_elems.push_back(m_part[i]);
                        m_part.delete();
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_elem(input logic [DW-1:0] d);
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        $display("FAIL push_timeout: in_ready stayed 0 expected 1 at %0t", $time);
    endtask

    task automatic push_n(input int n, input bit ramp);
        for (int i = 0; i < n; i++) push_elem(ramp ? DW'(i) : DW'($urandom));
    endtask

    task automatic pop_n(input int n, input logic rp);
        logic acc;
        replay = rp;
        for (int i = 0; i < n; i++) begin
            out_ready = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 500 && !acc; t++) begin
                @(negedge clk);
                acc = out_valid;
                tick();
            end
            if (!acc) begin
                n_checks++;
                $display("FAIL pop_timeout: out_valid stayed 0 expected 1 at %0t", $time);
                i = n;
            end
        end
        out_ready = 1'b0;
        replay    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenario sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        replay = 1'b0; flush = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single vector with ramp data, then drain it.
        push_n(ND, 1'b1);
        repeat (2) tick();
        pop_n(ND, 1'b0);
        tick();

        // Fill to full, hold one extra element against backpressure, pop one
        // vector so the held element enters, then drain and clean up.
        push_n(NV * ND, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hABCD_0129;
        repeat (4) tick();
        pop_n(ND, 1'b0);
        tick();
        in_valid = 1'b0;
        pop_n((NV - 1) * ND, 1'b0);
        do_flush();

        // Replay the head vector once, then consume it.
        push_n(ND, 1'b1);
        pop_n(ND, 1'b1);
        pop_n(ND, 1'b0);
        tick();

        // Commit of vector 3 coinciding with the pop of vector 1.
        push_n(2 * ND, 1'b0);
        push_n(ND - 1, 1'b0);
        pop_n(ND - 1, 1'b0);
        in_valid  = 1'b1;
        in_data   = DW'($urandom);
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        pop_n(2 * ND, 1'b0);

        // Flush during a partial write with one vector stored.
        push_n(ND, 1'b0);
        push_n(10, 1'b0);
        do_flush();
        tick();
        push_n(ND, 1'b0);
        pop_n(ND, 1'b0);

        // Reset mid-stream.
        push_n(ND + 8, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Random traffic with occasional flush.
        for (int c = 0; c < 3000; c++) begin
            logic acc;
            @(negedge clk);
            acc = in_valid && in_ready && !flush;
            tick();
            if (!in_valid || acc) begin
                in_valid = ($urandom % 4) != 0;
                in_data  = DW'($urandom);
            end
            out_ready = ($urandom % 2) != 0;
            replay    = ($urandom % 4) == 0;
            flush     = ($urandom % 128) == 0;
        end
        in_valid = 1'b0; out_ready = 1'b0; replay = 1'b0; flush = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vector_stream_buffer.md
Name: vector_stream_buffer

Overview:
Multi-vector circular buffer for streamed feature vectors of NUM_DIMENSIONS elements, each DATA_WIDTH bits, holding up to NUM_VECTORS complete vectors.
- Elements enter one per cycle via valid/ready.
- A vector becomes readable only once all its elements are written.
- Read side streams elements with index and last flag, and can replay the head vector instead of consuming it.
- Sits between the vector source and the distance/compute datapath; supersedes the free-running single-vector rotating buffer.

Parameters:
NUM_DIMENSIONS, 32, elements per vector (>=2)
DATA_WIDTH, 32, bits per element
NUM_VECTORS, 4, vector slots (>=1; power of two not required)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input element valid
in_ready  out  1  buffer accepts input element
in_data  in  DATA_WIDTH  input element
out_valid  out  1  head vector element available
out_ready  in  1  consumer accepts output element
out_data  out  DATA_WIDTH  head vector element at current read index
out_index  out  DIM_W  element index within vector, 0..NUM_DIMENSIONS-1
out_last  out  1  out_index == NUM_DIMENSIONS-1
replay  in  1  sampled at last-element handshake: 1 = keep head vector, rewind index
flush  in  1  synchronous clear of all pointers and count
vec_count  out  CNT_W  committed vectors, 0..NUM_VECTORS
full  out  1  vec_count == NUM_VECTORS
empty  out  1  vec_count == 0

Behaviour:
- Widths: DIM_W = max(1, clog2(NUM_DIMENSIONS)); PTR_W = max(1, clog2(NUM_VECTORS)); CNT_W = clog2(NUM_VECTORS+1).
- Storage: NUM_VECTORS*NUM_DIMENSIONS entries, addressed {vector slot, dim}.
- Reset (async): wr_dim, wr_vec, rd_dim, rd_vec and vec_count = 0. Outputs: in_ready=1, out_valid=0, out_index=0, out_last=0, full=0, empty=1. Storage contents are not reset unless the optional feature is enabled.
- Handshake: transfer occurs on a rising edge with valid && ready. Data must be held while valid && !ready.
- Write:
  - in_ready = !full, decoded from registered vec_count.
  - On accept: mem[wr_vec][wr_dim] <= in_data and wr_dim increments.
  - At wr_dim == NUM_DIMENSIONS-1: wr_dim wraps to 0, wr_vec wraps modulo NUM_VECTORS, and the vector commits (count +1).
  - A partially written vector is invisible to the reader.
- Read:
  - out_valid = !empty.
  - out_data = mem[rd_vec][rd_dim], combinational (zero latency).
  - out_index = rd_dim.
  - On accept, rd_dim increments.
  - On accepting the last element with replay=0: rd_dim wraps to 0, rd_vec advances modulo NUM_VECTORS, count -1.
  - On accepting the last element with replay=1: rd_dim wraps to 0; rd_vec and count are unchanged.
  - replay is ignored on non-last elements.
- Latency: a committed vector is visible (out_valid=1) the cycle after its last element is written.
- A slot freed by a pop raises in_ready the following cycle (no same-cycle bypass).
- Simultaneous commit and pop: vec_count unchanged; both pointers advance.
- full: writes are blocked, including the first element of the next vector. The partial-vector slot is always free while !full.
- flush:
  - Highest priority after reset; all pointers and count go to 0 next edge.
  - Handshakes in the flush cycle are discarded: no write, no pop.
  - A partial write in progress is lost.
- Reset mid-operation: immediate return to reset values; no residual out_valid.

Optional Feature:
Macro VSB_MEM_CLEAR_EN.
- Defined: storage is cleared to zero on rst and on flush, so out_data reads 0 for never-written entries.
- Undefined: storage has no reset or clear, which permits RAM inference. out_data is don't-care while out_valid=0.

Decomposition:
- Shared package vsb_pkg:
  - function safe_clog2(n), returning max(1, clog2(n));
  - localparam defaults NUM_DIMENSIONS_DEF=32, DATA_WIDTH_DEF=32, NUM_VECTORS_DEF=4.
- One sub-module, vsb_mod_counter: parametrised modulo-MAX counter with inc, clr and async rst inputs and a wrap output. Instantiated four times: wr_dim, wr_vec, rd_dim, rd_vec.

Test Plan:
- Assert rst mid-stream -> next cycle in_ready=1, out_valid=0, vec_count=0, empty=1, out_index=0.
- Write elements 0..31 with out_ready=0 -> out_valid rises the cycle after the 32nd accept. Then set out_ready=1 -> data 0..31, out_last only at index 31, empty=1 after the final pop.
- Write 4 vectors (128 elements) with out_ready=0 -> full=1, in_ready=0; the 129th element is not accepted. Pop one vector -> in_ready=1 on the cycle after the last pop.
- One vector stored; replay=1 at the first last-element handshake, 0 at the second -> 64 elements emitted (0..31 twice), vec_count stays 1 until the second last handshake, then 0.
- vec_count=2; commit of vector 3 coincides with pop of vector 1 -> vec_count stays 2; the next out_data is the first element of vector 2.
- flush after 10 elements of a partial write with 1 vector stored -> vec_count=0, out_valid=0; a new full vector then reads back correctly from slot 0.
